// File: rtl/cmd_ctrl.sv
// cmd_ctrl: SD/MMC-style CMD line controller.
// Serialises a 48-bit command frame (start, transmission bit, index, argument,
// CRC7, end bit) onto the CMD line, optionally waits for and receives a
// 48-bit response, validates it, then inserts NCC idle clocks before done.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        command request, sampled only while busy=0
//   cmd_index    6-bit command index (captured on accepted start)
//   cmd_arg      32-bit command argument (captured on accepted start)
//   resp_en      1 = expect a 48-bit response
//   resp_crc_en  1 = check response CRC7 (0 for R3)
//   busy         transaction in progress
//   done         one-cycle completion pulse
//   resp         response bits 45..8
//   crc_err      response CRC, transmission-bit or end-bit fault
//   timeout      no response start bit within NCR_MAX clocks
//   cmd_o        serial command data to the line driver
//   cmd_oe       line output enable to the driver
//   cmd_i        serial CMD line input from the driver
module cmd_ctrl #(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    input  logic        resp_crc_en,
    output logic        busy,
    output logic        done,
    output logic [37:0] resp,
    output logic        crc_err,
    output logic        timeout,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic        cmd_i
);

    localparam int unsigned CNT_A   = (NCR_MAX > 48) ? NCR_MAX : 48;
    localparam int unsigned CNT_TOP = (NCC > CNT_A) ? NCC : CNT_A;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        CHECK,
        GAP,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [47:0]   tx, tx_d;
    logic [47:0]   rx, rx_d;
    logic [37:0]   resp_q, resp_d;
    logic          err_q, err_d;
    logic          to_q, to_d;
    logic          ren_q, ren_d;
    logic          cen_q, cen_d;
    logic [39:0]   hdr;

    // CRC7, polynomial x^7 + x^3 + 1, zero seed, processed MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] din);
        logic [6:0]  c;
        logic [39:0] d;
        logic        fb;
        c = '0;
        d = din;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = d[39] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
            d = {d[38:0], 1'b0};
        end
        return c;
    endfunction

    assign hdr = {2'b01, cmd_index, cmd_arg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tx     <= '1;
            rx     <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
            ren_q  <= 1'b0;
            cen_q  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            tx     <= tx_d;
            rx     <= rx_d;
            resp_q <= resp_d;
            err_q  <= err_d;
            to_q   <= to_d;
            ren_q  <= ren_d;
            cen_q  <= cen_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tx_d    = tx;
        rx_d    = rx;
        resp_d  = resp_q;
        err_d   = err_q;
        to_d    = to_q;
        ren_d   = ren_q;
        cen_d   = cen_q;

        busy    = 1'b1;
        done    = 1'b0;
        cmd_oe  = 1'b0;
        cmd_o   = 1'b1;

        case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                if (state == DONE) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                if (start) begin
                    tx_d    = {hdr, crc7(hdr), 1'b1};
                    ren_d   = resp_en;
                    cen_d   = resp_crc_en;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                cmd_oe = 1'b1;
                cmd_o  = tx[47];
                tx_d   = {tx[46:0], 1'b1};
                if (cnt == CW'(47)) begin
                    cnt_d   = '0;
                    state_d = ren_q ? WAIT : GAP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end

            WAIT: begin
                // A start bit on the final permitted cycle still wins over timeout.
                if (!cmd_i) begin
                    rx_d    = {rx[46:0], cmd_i};
                    cnt_d   = '0;
                    state_d = RECV;
                end else if (cnt == CW'(NCR_MAX - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end

            RECV: begin
                rx_d = {rx[46:0], cmd_i};
                if (cnt == CW'(46)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end

            CHECK: begin
                resp_d  = rx[45:8];
                err_d   = rx[46] | ~rx[0] |
                          (cen_q & (rx[7:1] != crc7(rx[47:8])));
                cnt_d   = '0;
                state_d = GAP;
            end

            GAP: begin
                if (cnt == CW'(NCC - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp    = resp_q;
    assign crc_err = err_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_cmd_ctrl.sv
// Testbench for cmd_ctrl: a transaction-level model predicts every output on
// every cycle; directed vectors add literal checks of frames, latencies and
// response status.
module tb_cmd_ctrl;

    localparam int NCR  = 64;
    localparam int GAPN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        resp_en = 1'b0;
    logic        resp_crc_en = 1'b0;
    logic        cmd_i = 1'b1;
    logic        busy, done, crc_err, timeout, cmd_o, cmd_oe;
    logic [37:0] resp;

    int vectors = 0;
    int miscompares = 0;
    int dut_dones = 0;

    cmd_ctrl #(.NCR_MAX(NCR), .NCC(GAPN)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_en(resp_en), .resp_crc_en(resp_crc_en),
        .busy(busy), .done(done), .resp(resp), .crc_err(crc_err),
        .timeout(timeout), .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // CRC7 as the remainder of (data * x^7) divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc_div(input logic [39:0] d);
        logic [46:0] v;
        v = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        b = {2'b01, idx, arg};
        return {b, crc_div(b), 1'b1};
    endfunction

    // ---------------- transaction model ----------------
    // m_k = index of the current cycle counted from the first SEND cycle.
    bit          m_busy = 0, m_done = 0, m_to = 0, m_err = 0, m_ren = 0, m_cen = 0;
    logic [37:0] m_resp = '0;
    logic [47:0] m_frame = '0, m_rx = '0;
    int          m_k = 0, m_rxk = -1, m_donek = -1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_to = 0; m_err = 0; m_resp = '0;
            m_k = 0; m_rxk = -1; m_donek = -1;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_frame = mk_frame(cmd_index, cmd_arg);
                    m_ren = resp_en; m_cen = resp_crc_en;
                    m_busy = 1; m_k = 0; m_rxk = -1; m_to = 0; m_err = 0;
                    m_donek = resp_en ? -1 : 48 + GAPN;
                end
            end else begin
                if (m_ren && m_k >= 48) begin
                    if (m_rxk < 0) begin
                        if (m_k < 48 + NCR && !m_to) begin
                            if (!cmd_i) begin
                                m_rxk = m_k;
                                m_rx = {m_rx[46:0], cmd_i};
                            end else if (m_k == 48 + NCR - 1) begin
                                m_to = 1;
                                m_donek = m_k + 1 + GAPN;
                            end
                        end
                    end else if (m_k <= m_rxk + 47) begin
                        m_rx = {m_rx[46:0], cmd_i};
                    end else if (m_k == m_rxk + 48) begin
                        m_resp = m_rx[45:8];
                        m_err = m_rx[46] | ~m_rx[0] |
                                (m_cen && (m_rx[7:1] != crc_div(m_rx[47:8])));
                        m_donek = m_k + 1 + GAPN;
                    end
                end
                m_k++;
                if (m_k == m_donek) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        bit eoe, eo;
        forever begin
            @(negedge clk);
            #2;
            eoe = m_busy && (m_k < 48);
            eo  = eoe ? m_frame[47 - m_k] : 1'b1;
            chk("busy", 48'(busy), 48'(m_busy));
            chk("done", 48'(done), 48'(m_done));
            chk("cmd_oe", 48'(cmd_oe), 48'(eoe));
            chk("cmd_o", 48'(cmd_o), 48'(eo));
            chk("resp", 48'(resp), 48'(m_resp));
            chk("crc_err", 48'(crc_err), 48'(m_err));
            chk("timeout", 48'(timeout), 48'(m_to));
        end
    end

    always @(negedge clk) if (done === 1'b1) dut_dones++;

    // ---------------- stimulus ----------------
    int          lat;
    logic [47:0] cap;

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic re, input logic ce,
                           output int l, output logic [47:0] c);
        start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_en = re; resp_crc_en = ce;
        @(negedge clk);
        start = 1'b0; l = 0; c = '0;
        while (done !== 1'b1 && l < 300) begin
            if (l < 48) c = {c[46:0], cmd_o};
            if (l == 1) begin
                start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg;
                resp_en = ~re; resp_crc_en = ~ce;
            end
            if (l == 2) start = 1'b0;
            @(negedge clk);
            l++;
        end
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_wait: no done within %0d cycles", l);
        end
    endtask

    task automatic drive_resp(input logic [47:0] r, input int d);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (cmd_oe !== 1'b1 && n < 10);
        n = 0;
        while (cmd_oe !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        repeat (d) @(negedge clk);
        for (int i = 47; i >= 0; i--) begin
            cmd_i = r[i];
            @(negedge clk);
        end
        cmd_i = 1'b1;
    endtask

    initial begin
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_cmd_oe", 48'(cmd_oe), 48'd0);
        chk("rst_cmd_o", 48'(cmd_o), 48'd1);
        chk("rst_resp", 48'(resp), 48'd0);
        rst = 1'b1;
        @(negedge clk);

        chk("crc_model_cmd0", 48'(crc_div(40'h4000000000)), 48'h4A);
        chk("crc_model_r1", 48'(crc_div(40'h3700000120)), 48'h41);

        // CMD0, no response
        run_cmd(6'd0, 32'h0, 1'b0, 1'b0, lat, cap);
        chk("cmd0_frame", cap, 48'h400000000095);
        chk("cmd0_lat", 48'(lat), 48'd56);
        chk("cmd0_err", 48'(crc_err), 48'd0);
        chk("cmd0_to", 48'(timeout), 48'd0);

        // CMD8, started in the DONE cycle
        run_cmd(6'd8, 32'h000001AA, 1'b0, 1'b0, lat, cap);
        chk("cmd8_frame", cap, 48'h48000001AA87);
        chk("cmd8_lat", 48'(lat), 48'd56);
        repeat (2) @(negedge clk);

        // CMD55 with good R1 after 5 idle cycles
        fork
            run_cmd(6'd55, 32'h0, 1'b1, 1'b1, lat, cap);
            drive_resp(48'h370000012083, 5);
        join
        chk("cmd55_frame", cap, 48'h770000000065);
        chk("cmd55_lat", 48'(lat), 48'd110);
        chk("cmd55_resp", 48'(resp), 48'h3700000120);
        chk("cmd55_err", 48'(crc_err), 48'd0);
        chk("cmd55_to", 48'(timeout), 48'd0);

        // payload bit flipped, start bit in first WAIT cycle
        fork
            run_cmd(6'd55, 32'h0, 1'b1, 1'b1, lat, cap);
            drive_resp(48'h370000112083, 0);
        join
        chk("flip_lat", 48'(lat), 48'd105);
        chk("flip_resp", 48'(resp), 48'h3700001120);
        chk("flip_err", 48'(crc_err), 48'd1);

        // end bit 0
        fork
            run_cmd(6'd55, 32'h0, 1'b1, 1'b1, lat, cap);
            drive_resp(48'h370000012082, 2);
        join
        chk("endbit_lat", 48'(lat), 48'd107);
        chk("endbit_err", 48'(crc_err), 48'd1);

        // transmission bit 1, CRC check off
        fork
            run_cmd(6'd55, 32'h0, 1'b1, 1'b0, lat, cap);
            drive_resp(48'h770000012083, 1);
        join
        chk("txbit_resp", 48'(resp), 48'h3700000120);
        chk("txbit_err", 48'(crc_err), 48'd1);

        // bad CRC ignored, start bit on the last permitted WAIT cycle
        fork
            run_cmd(6'd41, 32'h40FF8000, 1'b1, 1'b0, lat, cap);
            drive_resp(48'h370000012003, 63);
        join
        chk("nocrc_lat", 48'(lat), 48'd168);
        chk("nocrc_err", 48'(crc_err), 48'd0);
        chk("nocrc_to", 48'(timeout), 48'd0);

        // no response: timeout after 64 WAIT cycles, resp kept
        run_cmd(6'd55, 32'h0, 1'b1, 1'b1, lat, cap);
        chk("to_lat", 48'(lat), 48'd120);
        chk("to_flag", 48'(timeout), 48'd1);
        chk("to_err", 48'(crc_err), 48'd0);
        chk("to_resp", 48'(resp), 48'h3700000120);

        // timeout cleared by the next accepted start
        run_cmd(6'd8, 32'h000001AA, 1'b0, 1'b0, lat, cap);
        chk("clr_to", 48'(timeout), 48'd0);
        chk("clr_frame", cap, 48'h48000001AA87);

        // reset at SEND bit 20
        start = 1'b1; cmd_index = 6'd0; cmd_arg = '0; resp_en = 1'b0; resp_crc_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_oe", 48'(cmd_oe), 48'd1);
        rst = 1'b0;
        #1;
        chk("abort_oe", 48'(cmd_oe), 48'd0);
        chk("abort_o", 48'(cmd_o), 48'd1);
        chk("abort_busy", 48'(busy), 48'd0);
        chk("abort_done", 48'(done), 48'd0);
        chk("abort_resp", 48'(resp), 48'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(6'd0, 32'h0, 1'b0, 1'b0, lat, cap);
        chk("post_rst_frame", cap, 48'h400000000095);
        chk("post_rst_lat", 48'(lat), 48'd56);
        @(negedge clk);
        chk("done_count", 48'(dut_dones), 48'd10);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_ctrl.md
CMD_CTRL -- requirements
Module: cmd_ctrl

Interface
REQ-001 SHALL have parameter NCR_MAX, default 64, meaning maximum clocks waited for a response start bit.
REQ-002 SHALL have parameter NCC, default 8, meaning idle clocks inserted after every transaction before done.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  command request, sampled only when busy=0.
REQ-006 SHALL have port cmd_index  input  6  command index, captured on an accepted start.
REQ-007 SHALL have port cmd_arg  input  32  command argument, captured on an accepted start.
REQ-008 SHALL have port resp_en  input  1  1=expect 48-bit response, captured on an accepted start.
REQ-009 SHALL have port resp_crc_en  input  1  1=check response CRC7 (0 for R3), captured on an accepted start.
REQ-010 SHALL have port busy  output  1  transaction in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp  output  38  received response bits 45..8 (index + payload).
REQ-013 SHALL have port crc_err  output  1  response CRC, transmission-bit or end-bit fault.
REQ-014 SHALL have port timeout  output  1  no response start bit within NCR_MAX clocks.
REQ-015 SHALL have port cmd_o  output  1  serial command data to the CMD line driver.
REQ-016 SHALL have port cmd_oe  output  1  CMD line output enable to the driver.
REQ-017 SHALL have port cmd_i  input  1  serial CMD line input from the driver.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT, RECV, CHECK, GAP, DONE.
REQ-019 SHALL accept start only in IDLE or DONE (busy=0), capture the inputs, go to SEND, and assert busy on the next cycle.
REQ-020 SHALL build the frame as 0, 1, cmd_index, cmd_arg, CRC7, 1, i.e. 48 bits MSB first.
REQ-021 SHALL compute CRC7 with polynomial x^7+x^3+1 and zero seed over frame bits 47..8.
REQ-022 SHALL in SEND drive cmd_oe=1 and one frame bit per cycle on cmd_o for exactly 48 cycles, with the start bit in the first SEND cycle.
REQ-023 SHALL drive cmd_oe=0 and cmd_o=1 in every state other than SEND.
REQ-024 SHALL after SEND go to WAIT when resp_en=1, otherwise to GAP.
REQ-025 SHALL in WAIT sample cmd_i each cycle and enter RECV on the first 0 (the start bit), counting that bit as received bit 47.
REQ-026 SHALL, if WAIT has lasted NCR_MAX cycles without cmd_i=0, set timeout=1 and go to GAP.
REQ-027 SHALL in RECV shift in the remaining 47 bits, then go to CHECK.
REQ-028 SHALL in CHECK (one cycle) load resp from bits 45..8.
REQ-029 SHALL in CHECK set crc_err=1 if the transmission bit 46 is not 0, if end bit 0 is not 1, or if resp_crc_en=1 and bits 7..1 differ from the CRC7 of bits 47..8.
REQ-030 SHALL go from CHECK to GAP.
REQ-031 SHALL hold GAP for NCC cycles, then enter DONE.
REQ-032 SHALL in DONE assert done=1 and busy=0 for one cycle, then go to IDLE; a start in that cycle is accepted.
REQ-033 SHALL clear crc_err and timeout on an accepted start and hold them from CHECK/timeout until the next accepted start.
REQ-034 SHALL hold resp from CHECK until the next CHECK, leaving it unchanged on timeout.
REQ-035 SHALL ignore start, cmd_index, cmd_arg, resp_en and resp_crc_en changes while busy=1.
REQ-036 SHALL treat a response start bit that arrives in the first WAIT cycle as valid.

Reset
REQ-037 SHALL, while rst=0, immediately force IDLE, busy=0, done=0, cmd_oe=0, cmd_o=1, resp=0, crc_err=0, timeout=0 and clear all counters.
REQ-038 SHALL abort an in-progress transaction on reset without a done pulse and resume normal operation on the first edge after release.

Verification
REQ-039 SHALL verify: start, CMD0, arg 0x00000000, resp_en=0 -> cmd_o serialises 0x400000000095 over 48 cycles with cmd_oe=1, then 8 GAP cycles, then done with crc_err=0 and timeout=0.
REQ-040 SHALL verify: CMD8, arg 0x000001AA -> frame 0x48000001AA87 on cmd_o.
REQ-041 SHALL verify: CMD55 with resp_en=1 and resp_crc_en=1, bench returns 0x370000012083 after 5 idle cycles -> resp=0x37000001 20 (bits 45..8 = 0x3700000120 with the leading 2 bits dropped), crc_err=0, done once.
REQ-042 SHALL verify: the same response with one payload bit flipped -> crc_err=1; end bit forced 0 -> crc_err=1; resp_crc_en=0 with a bad CRC -> crc_err=0.
REQ-043 SHALL verify: resp_en=1 with cmd_i held at 1 -> timeout=1 after exactly 64 WAIT cycles, then done 8 cycles later, with resp unchanged.
REQ-044 SHALL verify: rst pulled low at SEND bit 20 -> cmd_oe=0 at once with no done; a new CMD0 start after release produces the full correct frame.
